// File: rtl/lot_occupancy_cnt.sv
// lot_occupancy_cnt: parking-lot occupancy counter.
// Each lane has an outer (a) and an inner (b) beam sensor. A per-lane FSM
// decodes the order in which the beams break into entry/exit events. The
// combined events update a clamped 0..CAP count, which is also shown on two
// 7-segment digits.
module lot_occupancy_cnt #(
  parameter int LANES = 2,
  parameter int CAP   = 99,
  parameter int LZB   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [LANES-1:0] sens_a,
  input  logic [LANES-1:0] sens_b,
  output logic [6:0]       count,
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_ones,
  output logic             full,
  output logic             empty,
  output logic [LANES-1:0] lane_err,
  output logic             ovf
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_BA = 3'd5,
    EX_A  = 3'd6,
    ERR   = 3'd7
  } lane_state_t;

  localparam logic signed [8:0] CAP_S = 9'(CAP);
  localparam logic [6:0]        CAP_U = 7'(CAP);

  // 7-segment pattern {a,b,c,d,e,f,g}; anything that is not a digit is dark
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [LANES-1:0] r_a_s1, r_a_s2, r_b_s1, r_b_s2;
  lane_state_t      r_state [LANES];
  lane_state_t      w_next  [LANES];
  logic [LANES-1:0] w_entry, w_exit, w_to_err;
  logic [1:0]       w_ab;
  logic signed [8:0] w_sum;
  logic [6:0]       w_count_nxt;
  logic             w_ovf;
  logic [3:0]       w_tens, w_ones;

  // Two-flop synchronizers for the raw sensor beams
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
    end else if (clr) begin
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
    end else begin
      r_a_s1 <= sens_a;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= sens_b;
      r_b_s2 <= r_b_s1;
    end
  end

  // Lane next-state decode on synchronized {b,a}; exit path mirrors entry
  always_comb begin
    w_ab     = 2'b00;
    w_entry  = '0;
    w_exit   = '0;
    w_to_err = '0;
    for (int i = 0; i < LANES; i++) begin
      w_ab      = {r_b_s2[i], r_a_s2[i]};
      w_next[i] = r_state[i];
      case (r_state[i])
        IDLE: begin
          if (w_ab == 2'b01)      w_next[i] = EN_A;
          else if (w_ab == 2'b10) w_next[i] = EX_B;
          else if (w_ab == 2'b11) w_next[i] = ERR;
          else                    w_next[i] = IDLE;
        end
        EN_A: begin
          if (w_ab == 2'b11)      w_next[i] = EN_AB;
          else if (w_ab == 2'b00) w_next[i] = IDLE;
          else if (w_ab == 2'b10) w_next[i] = ERR;
          else                    w_next[i] = EN_A;
        end
        EN_AB: begin
          if (w_ab == 2'b10)      w_next[i] = EN_B;
          else if (w_ab == 2'b01) w_next[i] = EN_A;
          else if (w_ab == 2'b00) w_next[i] = ERR;
          else                    w_next[i] = EN_AB;
        end
        EN_B: begin
          if (w_ab == 2'b00) begin
            w_next[i]  = IDLE;
            w_entry[i] = 1'b1;
          end else if (w_ab == 2'b11) w_next[i] = EN_AB;
          else if (w_ab == 2'b01)     w_next[i] = ERR;
          else                        w_next[i] = EN_B;
        end
        EX_B: begin
          if (w_ab == 2'b11)      w_next[i] = EX_BA;
          else if (w_ab == 2'b00) w_next[i] = IDLE;
          else if (w_ab == 2'b01) w_next[i] = ERR;
          else                    w_next[i] = EX_B;
        end
        EX_BA: begin
          if (w_ab == 2'b01)      w_next[i] = EX_A;
          else if (w_ab == 2'b10) w_next[i] = EX_B;
          else if (w_ab == 2'b00) w_next[i] = ERR;
          else                    w_next[i] = EX_BA;
        end
        EX_A: begin
          if (w_ab == 2'b00) begin
            w_next[i] = IDLE;
            w_exit[i] = 1'b1;
          end else if (w_ab == 2'b11) w_next[i] = EX_BA;
          else if (w_ab == 2'b10)     w_next[i] = ERR;
          else                        w_next[i] = EX_A;
        end
        ERR: begin
          if (w_ab == 2'b00) w_next[i] = IDLE;
          else               w_next[i] = ERR;
        end
        default: w_next[i] = IDLE;
      endcase
      w_to_err[i] = (w_next[i] == ERR) && (r_state[i] != ERR);
    end
  end

  // Net all lane events into one signed sum, then clamp to 0..CAP
  always_comb begin
    w_sum = $signed({2'b00, count});
    for (int i = 0; i < LANES; i++) begin
      if (w_entry[i]) w_sum = w_sum + 9'sd1;
      else            w_sum = w_sum;
      if (w_exit[i])  w_sum = w_sum - 9'sd1;
      else            w_sum = w_sum;
    end
    if (w_sum > CAP_S) begin
      w_count_nxt = CAP_U;
      w_ovf       = 1'b1;
    end else if (w_sum < 9'sd0) begin
      w_count_nxt = 7'd0;
      w_ovf       = 1'b1;
    end else begin
      w_count_nxt = w_sum[6:0];
      w_ovf       = 1'b0;
    end
  end

  // Lane states, count, flags and pulses; clear wins over any event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) r_state[i] <= IDLE;
      count    <= 7'd0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      lane_err <= '0;
    end else if (clr) begin
      for (int i = 0; i < LANES; i++) r_state[i] <= IDLE;
      count    <= 7'd0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      lane_err <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) r_state[i] <= w_next[i];
      count    <= w_count_nxt;
      full     <= (w_count_nxt == CAP_U);
      empty    <= (w_count_nxt == 7'd0);
      ovf      <= w_ovf;
      lane_err <= w_to_err;
    end
  end

  // Decimal digits straight from the registered count
  assign w_tens   = 4'(count / 7'd10);
  assign w_ones   = 4'(count % 7'd10);
  assign seg_tens = ((LZB != 0) && (w_tens == 4'd0)) ? 7'b0000000 : f_seg(w_tens);
  assign seg_ones = f_seg(w_ones);

endmodule

// File: tb/tb_lot_occupancy_cnt.sv
// Directed bench for lot_occupancy_cnt: a table of lane-operation vectors
// plus hand-written sequences for latency, errors, reset and saturation.
module tb_lot_occupancy_cnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clr, use3;
  logic [1:0] sa, sb;
  logic [1:0] sa_m, sb_m, sa_3, sb_3;

  assign sa_m = use3 ? 2'b00 : sa;
  assign sb_m = use3 ? 2'b00 : sb;
  assign sa_3 = use3 ? sa : 2'b00;
  assign sb_3 = use3 ? sb : 2'b00;

  logic [6:0] count, seg_tens, seg_ones;
  logic       full, empty, ovf;
  logic [1:0] lane_err;
  logic [6:0] count3, seg_tens3, seg_ones3;
  logic       full3, empty3, ovf3;
  logic [1:0] lane_err3;

  lot_occupancy_cnt #(.LANES(2), .CAP(99), .LZB(0)) dut (
    .clk(clk), .reset(reset), .clr(clr), .sens_a(sa_m), .sens_b(sb_m),
    .count(count), .seg_tens(seg_tens), .seg_ones(seg_ones),
    .full(full), .empty(empty), .lane_err(lane_err), .ovf(ovf));

  lot_occupancy_cnt #(.LANES(2), .CAP(3), .LZB(1)) dut3 (
    .clk(clk), .reset(reset), .clr(clr), .sens_a(sa_3), .sens_b(sb_3),
    .count(count3), .seg_tens(seg_tens3), .seg_ones(seg_ones3),
    .full(full3), .empty(empty3), .lane_err(lane_err3), .ovf(ovf3));

  int checks = 0;
  int errors = 0;
  int e0 = 0;
  int e1 = 0;

  // count cycles in which each lane_err bit of the main instance is high
  always begin
    @(posedge clk);
    #1;
    if (lane_err[0]) e0++;
    if (lane_err[1]) e1++;
  end

  typedef struct {
    logic [1:0] op0;   // 0 none, 1 entry, 2 exit
    logic [1:0] op1;
    int         cnt;
    logic       ovf;
    logic       full;
    logic       empty;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // raw {b,a} pattern for step k of an operation
  function automatic logic [1:0] pat(input logic [1:0] op, input int k);
    if (op == 2'd1) begin
      case (k)
        0: return 2'b01;
        1: return 2'b11;
        2: return 2'b10;
        default: return 2'b00;
      endcase
    end else if (op == 2'd2) begin
      case (k)
        0: return 2'b10;
        1: return 2'b11;
        2: return 2'b01;
        default: return 2'b00;
      endcase
    end else begin
      return 2'b00;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] p0, input logic [1:0] p1);
    sa[0] = p0[0]; sb[0] = p0[1];
    sa[1] = p1[0]; sb[1] = p1[1];
  endtask

  // run one operation per lane in parallel; returns 3 edges after final 00
  task automatic run_ops(input logic [1:0] op0, input logic [1:0] op1);
    for (int k = 0; k < 3; k++) begin
      drive(pat(op0, k), pat(op1, k));
      step(4);
    end
    drive(2'b00, 2'b00);
    step(3);
  endtask

  int e_snap;

  initial begin
    //                op0   op1   cnt ovf   full  empty
    tbl[0] = '{2'd1, 2'd0, 1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{2'd0, 2'd1, 2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{2'd1, 2'd1, 4, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{2'd2, 2'd1, 4, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2'd2, 2'd2, 2, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{2'd2, 2'd0, 1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{2'd0, 2'd2, 0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{2'd2, 2'd0, 0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{2'd1, 2'd2, 0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{2'd2, 2'd2, 0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; clr = 1'b0; use3 = 1'b0; sa = 2'b00; sb = 2'b00;
    step(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_lane_err", lane_err, 0);
    chk("rst_seg_tens", seg_tens, 7'b1111110);
    chk("rst_seg_ones", seg_ones, 7'b1111110);
    chk("rst_lzb_tens", seg_tens3, 7'b0000000);
    chk("rst_lzb_ones", seg_ones3, 7'b1111110);
    reset = 1'b0;
    step(2);

    // table of lane operations
    for (int i = 0; i < 10; i++) begin
      run_ops(tbl[i].op0, tbl[i].op1);
      chk($sformatf("v%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("v%0d_full", i), full, tbl[i].full);
      chk($sformatf("v%0d_empty", i), empty, tbl[i].empty);
      chk($sformatf("v%0d_seg_ones", i), seg_ones, seg_of(tbl[i].cnt % 10));
      chk($sformatf("v%0d_seg_tens", i), seg_tens, seg_of(tbl[i].cnt / 10));
      step(2);
      chk($sformatf("v%0d_ovf_gone", i), ovf, 0);
    end
    chk("tbl_no_lane_err", e0 + e1, 0);

    // back-out on lane0: no count, no error
    drive(2'b01, 2'b00); step(4);
    drive(2'b00, 2'b00); step(6);
    chk("backout_count", count, 0);
    chk("backout_err", e0, 0);

    // exact latency of an entry on lane0
    drive(2'b01, 2'b00); step(4);
    drive(2'b11, 2'b00); step(4);
    drive(2'b10, 2'b00); step(4);
    drive(2'b00, 2'b00); step(2);
    chk("lat_edge2_count", count, 0);
    chk("lat_edge2_empty", empty, 1);
    step(1);
    chk("lat_edge3_count", count, 1);
    chk("lat_edge3_empty", empty, 0);
    chk("lat_seg_ones", seg_ones, 7'b0110000);
    step(2);

    // lane1 jumps 00->11: one error pulse, ERR holds until 00
    e_snap = e1;
    drive(2'b00, 2'b11); step(8);
    chk("err_pulse_width", e1 - e_snap, 1);
    drive(2'b00, 2'b10); step(4);
    drive(2'b00, 2'b11); step(4);
    drive(2'b00, 2'b01); step(4);
    drive(2'b00, 2'b00); step(4);
    chk("err_hold_count", count, 1);
    chk("err_hold_single", e1 - e_snap, 1);
    run_ops(2'd0, 2'd1);
    chk("after_err_entry", count, 2);
    step(2);

    // clr on the same edge as an entry event wins
    drive(2'b01, 2'b00); step(4);
    drive(2'b11, 2'b00); step(4);
    drive(2'b10, 2'b00); step(4);
    drive(2'b00, 2'b00); step(2);
    chk("clr_pre_count", count, 2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    step(3);
    chk("clr_stays", count, 0);

    // raise to 42, then reset during EN_AB
    for (int i = 0; i < 21; i++) begin
      run_ops(2'd1, 2'd1);
      step(1);
    end
    chk("c42_count", count, 42);
    chk("c42_seg_tens", seg_tens, 7'b0110011);
    chk("c42_seg_ones", seg_ones, 7'b1101101);
    drive(2'b01, 2'b00); step(4);
    drive(2'b11, 2'b00); step(4);
    reset = 1'b1;
    #1;
    chk("midrst_count_async", count, 0);
    step(2);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_seg_tens", seg_tens, 7'b1111110);
    chk("midrst_seg_ones", seg_ones, 7'b1111110);
    reset = 1'b0;
    step(4);
    drive(2'b10, 2'b00); step(4);
    drive(2'b00, 2'b00); step(6);
    chk("midrst_discard", count, 0);

    // CAP=3 instance with leading-zero blanking
    use3 = 1'b1;
    step(4);
    for (int k = 1; k <= 4; k++) begin
      run_ops(2'd1, 2'd0);
      chk($sformatf("cap_e%0d_count", k), count3, (k > 3) ? 3 : k);
      chk($sformatf("cap_e%0d_full", k), full3, (k >= 3) ? 1 : 0);
      chk($sformatf("cap_e%0d_ovf", k), ovf3, (k == 4) ? 1 : 0);
      chk($sformatf("cap_e%0d_tens", k), seg_tens3, 7'b0000000);
      chk($sformatf("cap_e%0d_ones", k), seg_ones3, seg_of((k > 3) ? 3 : k));
      step(2);
    end
    chk("cap_main_idle", count, 0);
    use3 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
